// File: rtl/fifo_wr_gen.sv
// Read-domain writer for the return FIFO: when the far side reports the FIFO
// empty, waits a settle period and then fills it with an incrementing byte
// pattern until almost_full marks the last free slot.
`timescale 1ns/1ps
module fifo_wr_gen #(
    parameter logic [7:0]  START_VAL = 8'd1,
    parameter int unsigned DLY       = 10
) (
    input  logic        rd_clk,
    input  logic        rst_n,
    input  logic        empty,
    input  logic        almost_full,
    input  logic        full,
    input  logic        wr_rst_busy,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic [15:0] burst_cnt,
    output logic        ovf_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Last counter value of the settle period; DELAY lasts DLY cycles.
    localparam logic [7:0] DLY_LAST = 8'(DLY - 1);

    logic        empty_d0;
    logic        empty_d1;

    state_t      state_q,     state_d;
    logic [7:0]  dly_cnt_q,   dly_cnt_d;
    logic        wr_en_q,     wr_en_d;
    logic [7:0]  wr_data_q,   wr_data_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic        ovf_err_q,   ovf_err_d;

    // Two-flop synchronizer bringing the far-side empty flag into rd_clk.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            empty_d0 <= 1'b0;
            empty_d1 <= 1'b0;
        end else begin
            empty_d0 <= empty;
            empty_d1 <= empty_d0;
        end
    end

    // Next-state and next-output logic; wr_rst_busy outranks overflow,
    // which outranks the almost_full end-of-burst condition.
    always_comb begin
        state_d     = state_q;
        dly_cnt_d   = dly_cnt_q;
        wr_en_d     = wr_en_q;
        wr_data_d   = wr_data_q;
        burst_cnt_d = burst_cnt_q;
        ovf_err_d   = ovf_err_q;

        case (state_q)
            IDLE: begin
                wr_en_d = 1'b0;
                if (empty_d1 && !wr_rst_busy) begin
                    state_d   = DELAY;
                    dly_cnt_d = 8'd0;
                end
            end

            DELAY: begin
                wr_en_d = 1'b0;
                if (wr_rst_busy) begin
                    state_d = IDLE;
                end else if (dly_cnt_q == DLY_LAST) begin
                    state_d   = WRITE;
                    wr_en_d   = 1'b1;
                    wr_data_d = START_VAL;
                end else begin
                    dly_cnt_d = dly_cnt_q + 8'd1;
                end
            end

            WRITE: begin
                if (wr_rst_busy) begin
                    // Abandon the burst; data holds so the stall is visible.
                    state_d = IDLE;
                    wr_en_d = 1'b0;
                end else if (wr_en_q && full) begin
                    // Write refused by a full FIFO: flag it and give up.
                    state_d   = IDLE;
                    wr_en_d   = 1'b0;
                    ovf_err_d = 1'b1;
                end else if (wr_en_q) begin
                    // Accepted write; almost_full means this was the last slot.
                    wr_data_d = wr_data_q + 8'd1;
                    if (almost_full) begin
                        state_d     = IDLE;
                        wr_en_d     = 1'b0;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dly_cnt_q   <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= START_VAL;
            burst_cnt_q <= 16'd0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dly_cnt_q   <= dly_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            burst_cnt_q <= burst_cnt_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign burst_cnt    = burst_cnt_q;
    assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Bench for fifo_wr_gen: a depth-256 FIFO model with a far-side drain, a
// scoreboard of expected write data, and directed burst scenarios.
`timescale 1ns/1ps
module tb_fifo_wr_gen;

    logic        rd_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        wr_rst_busy = 1'b0;
    logic        force_full = 1'b0;
    logic        force_empty_en = 1'b0;
    logic        force_empty_val = 1'b0;
    logic        drain = 1'b0;
    int          fcnt = 0;

    logic        empty;
    logic        full;
    logic        almost_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [15:0] burst_cnt;
    logic        ovf_err;

    int n_cmp = 0;
    int n_bad = 0;
    int writes_seen = 0;
    int exp_q[$];

    assign full        = force_full || (fcnt == 256);
    assign almost_full = !force_full && (fcnt == 255);
    assign empty       = force_empty_en ? force_empty_val : (fcnt == 0);

    fifo_wr_gen dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .empty        (empty),
        .almost_full  (almost_full),
        .full         (full),
        .wr_rst_busy  (wr_rst_busy),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .burst_cnt    (burst_cnt),
        .ovf_err      (ovf_err)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO occupancy model: accepted writes fill, the far reader drains.
    always @(posedge rd_clk) begin
        fcnt <= fcnt + ((fifo_wr_en && !full && !wr_rst_busy) ? 1 : 0)
                     - ((drain && fcnt > 0) ? 1 : 0);
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Monitor: every write the FIFO accepts is checked against the scoreboard.
    initial begin
        int exp;
        forever begin
            @(negedge rd_clk);
            if (rst_n && fifo_wr_en && !full && !wr_rst_busy) begin
                writes_seen++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got data %0d, want no write", fifo_wr_data);
                end else begin
                    exp = exp_q.pop_front();
                    chk("wr_data", int'(fifo_wr_data), exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back((first + i) & 255);
    endtask

    task automatic wait_rise(input string name, input int want);
        int c;
        c = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge rd_clk); #1;
            if (fifo_wr_en) begin
                c = i;
                break;
            end
        end
        chk(name, c, want);
    endtask

    task automatic wait_data(input string name, input logic [7:0] v);
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge rd_clk); #1;
            if (fifo_wr_en && fifo_wr_data == v) begin
                ok = 1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_end(input string name, input int want_writes);
        int w0;
        int ended;
        w0 = writes_seen;
        ended = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge rd_clk); #1;
            if (!fifo_wr_en) begin
                ended = 1;
                break;
            end
        end
        chk({name, "_ended"}, ended, 1);
        chk({name, "_writes"}, writes_seen - w0, want_writes);
    endtask

    task automatic drain_empty(input string name);
        drain = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge rd_clk); #1;
            if (fcnt == 0) break;
        end
        drain = 1'b0;
        chk(name, fcnt, 0);
    endtask

    initial begin
        int rise;
        int w0;
        int highs;

        // Reset state
        repeat (3) @(posedge rd_clk);
        #1;
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wr_data", fifo_wr_data, 1);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_ovf_err", ovf_err, 0);

        // First burst straight out of reset: 256 writes of 1..255,0
        push_seq(1, 256);
        @(negedge rd_clk);
        rst_n = 1'b1;
        wait_rise("t1_start_latency", 13);
        wait_end("t1_burst", 256);
        chk("t1_burst_cnt", burst_cnt, 1);
        chk("t1_fifo_level", fcnt, 256);

        // Far reader drains, second burst restarts at 1
        push_seq(1, 256);
        drain_empty("t2_drain");
        wait_rise("t2_start_latency", 13);
        wait_end("t2_burst", 256);
        chk("t2_burst_cnt", burst_cnt, 2);

        // Forced full mid-burst: overflow, abort, no burst count
        push_seq(1, 4);
        drain_empty("t3_drain");
        wait_rise("t3_start_latency", 13);
        wait_data("t3_reach_5", 8'd5);
        force_full = 1'b1;
        @(posedge rd_clk); #1;
        chk("t3_ovf_err", ovf_err, 1);
        chk("t3_wr_en", fifo_wr_en, 0);
        chk("t3_burst_cnt", burst_cnt, 2);
        force_full = 1'b0;
        highs = 0;
        repeat (6) begin
            @(posedge rd_clk); #1;
            if (fifo_wr_en) highs++;
        end
        chk("t3_stays_idle", highs, 0);
        chk("t3_ovf_sticky", ovf_err, 1);

        // wr_rst_busy for 5 cycles mid-burst while the FIFO drains empty
        push_seq(1, 2);
        drain_empty("t4_drain");
        wait_rise("t4_start_latency", 13);
        wait_data("t4_reach_3", 8'd3);
        wr_rst_busy = 1'b1;
        drain = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge rd_clk); #1;
            chk("t4_busy_wr_en", fifo_wr_en, 0);
        end
        chk("t4_data_hold", fifo_wr_data, 3);
        chk("t4_burst_cnt", burst_cnt, 2);
        chk("t4_fifo_empty", fcnt, 0);
        wr_rst_busy = 1'b0;
        drain = 1'b0;
        push_seq(1, 256);
        wait_rise("t4_restart_latency", 11);
        wait_end("t4_burst", 256);
        chk("t4_burst_cnt_after", burst_cnt, 3);

        // Empty toggling during DELAY and WRITE has no effect
        push_seq(1, 256);
        drain_empty("t5_drain");
        rise = 0;
        w0 = writes_seen;
        for (int i = 1; i <= 400; i++) begin
            @(posedge rd_clk); #1;
            if (fifo_wr_en && rise == 0) rise = i;
            if (rise != 0 && !fifo_wr_en) break;
            force_empty_en  = (i >= 4) && (fcnt < 240);
            force_empty_val = i[0];
        end
        force_empty_en = 1'b0;
        chk("t5_start_latency", rise, 13);
        chk("t5_writes", writes_seen - w0, 256);
        chk("t5_burst_cnt", burst_cnt, 4);
        chk("t5_ovf_sticky", ovf_err, 1);

        // Reset pulse mid-WRITE at data 8'h40
        push_seq(1, 63);
        drain_empty("t6_drain");
        wait_rise("t6_start_latency", 13);
        wait_data("t6_reach_40", 8'h40);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", fifo_wr_en, 0);
        chk("t6_rst_wr_data", fifo_wr_data, 1);
        chk("t6_rst_burst_cnt", burst_cnt, 0);
        chk("t6_rst_ovf_err", ovf_err, 0);
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        rst_n = 1'b1;
        highs = 0;
        repeat (20) begin
            @(posedge rd_clk); #1;
            if (fifo_wr_en) highs++;
        end
        chk("t6_no_writes_after_rst", highs, 0);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
